// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one serial line between N_REQ byte sources. A free-running
//   10-slot frame counter (slot 0 = start bit 0, slots 1..8 = data LSB
//   first, slot 9 = stop bit 1) runs in lockstep with a slot-locked receiver
//   that leaves reset on the same edge. Ownership of each frame is decided
//   round-robin on the slot-9 edge. Frames with no owner carry IDLE_BYTE.
//
//   Request/grant handshake: req[i] acts as a valid that the source holds,
//   with data[8*i+7:8*i] stable, until it sees grant[i]. grant[i] acts as the
//   ready/accept. It is a one-cycle pulse in slot 0, and a transfer happens
//   only in that cycle. Dropping req[i] before a slot-9 edge simply withdraws
//   it. Leaving req[i] high after grant[i] offers a new byte for the next
//   slot-9 edge.
//
//   The slot counter is the only sequencing state, and it is exported on
//   `slot` so frame position can be observed directly.
module serial_tx_arbiter #(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         grant_id,
  output logic               active,
  output logic [3:0]         slot,
  output logic               frame_end,
  output logic               tx
);

  // Slot numbers that carry meaning within the frame.
  localparam logic [3:0] SLOT_FIRST = 4'd0;
  localparam logic [3:0] SLOT_MSB   = 4'd8;
  localparam logic [3:0] SLOT_LAST  = 4'd9;

  // After reset the last owner is the top index, so requester 0 is searched first.
  localparam logic [2:0] LAST_RESET = 3'(N_REQ - 1);

  // Registered state.
  logic [3:0]       slot_q,     slot_d;
  logic             tx_q,       tx_d;
  logic [7:0]       shift_q,    shift_d;
  logic [2:0]       last_q,     last_d;
  logic [N_REQ-1:0] grant_q,    grant_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic             active_q,   active_d;

  // Arbitration results, evaluated every cycle but used only in slot 9.
  logic             at_last;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [7:0]       win_byte;
  logic [N_REQ-1:0] win_onehot;

  assign at_last = (slot_q == SLOT_LAST);

  // Round-robin search: take the first request above last_q, else wrap to the lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && (3'(i) > last_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && (3'(i) <= last_q)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end

  // Select the winner's byte and build its one-hot grant vector.
  always_comb begin
    win_byte   = IDLE_BYTE;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_found && (win_idx == 3'(i))) begin
        win_byte      = data[8*i +: 8];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state logic: the slot counter, line encoding for the next slot,
  // and the frame latch on the slot-9 edge.
  always_comb begin
    slot_d     = at_last ? SLOT_FIRST : slot_q + 4'd1;
    tx_d       = tx_q;
    shift_d    = shift_q;
    last_d     = last_q;
    grant_id_d = grant_id_q;
    active_d   = active_q;
    grant_d    = '0;

    if (at_last) begin
      // The next slot is 0 (start bit), and the next frame's byte is chosen here.
      tx_d = 1'b0;
      if (win_found) begin
        shift_d    = win_byte;
        last_d     = win_idx;
        grant_id_d = win_idx;
        active_d   = 1'b1;
        grant_d    = win_onehot;
      end else begin
        shift_d  = IDLE_BYTE;
        active_d = 1'b0;
      end
    end else if (slot_q < SLOT_MSB) begin
      // The next slot is 1..8: present the next data bit, LSB first.
      tx_d    = shift_q[0];
      shift_d = {1'b0, shift_q[7:1]};
    end else begin
      // The next slot is 9 (stop bit).
      tx_d = 1'b1;
    end
  end

  // State registers. Asynchronous reset drops any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q     <= SLOT_FIRST;
      tx_q       <= 1'b0;
      shift_q    <= IDLE_BYTE;
      last_q     <= LAST_RESET;
      grant_q    <= '0;
      grant_id_q <= 3'd0;
      active_q   <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      active_q   <= active_d;
    end
  end

  assign slot      = slot_q;
  assign frame_end = at_last;
  assign tx        = tx_q;
  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (N_REQ=4, IDLE_BYTE=8'h00).
// A bench-side slot counter, reset together with the DUT, stands in for the
// slot-locked receiver. Each frame is sampled on falling edges into f_*
// variables, and every scenario task compares those against hand-derived
// expectations.
module tb_serial_tx_arbiter;

  localparam int N_REQ = 4;

  // Clock/reset and DUT connections.
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [2:0]  grant_id;
  logic        active;
  logic [3:0]  slot;
  logic        frame_end;
  logic        tx;

  int tests_run    = 0;
  int tests_failed = 0;

  // Receiver slot counter: it free-runs from reset like the link receiver.
  logic [3:0] tb_slot;

  // Results of the most recently collected frame.
  logic [7:0] f_rx;
  logic [9:0] f_bits;
  logic [3:0] f_g0;
  logic       f_glate;
  logic       f_actlo;
  logic       f_acthi;
  logic [2:0] f_gid;
  logic       f_misc;
  logic       f_to;

  serial_tx_arbiter #(.N_REQ(N_REQ), .IDLE_BYTE(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .grant_id  (grant_id),
    .active    (active),
    .slot      (slot),
    .frame_end (frame_end),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) tb_slot <= 4'd0;
    else        tb_slot <= (tb_slot == 4'd9) ? 4'd0 : tb_slot + 4'd1;
  end

  // Overall time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // Driver: align to slot 0 (bounded), sample all 10 slots on falling edges
  // and apply up to two input updates after the sample of the given slots.
  task automatic collect_frame(input int sa, input logic [3:0] ra, input logic [31:0] da,
                               input int sb, input logic [3:0] rb, input logic [31:0] db);
    int n = 0;
    f_to = 1'b0; f_glate = 1'b0; f_actlo = 1'b0; f_acthi = 1'b0; f_misc = 1'b0;
    f_rx = 8'h00; f_bits = '0; f_g0 = '0; f_gid = '0;
    while (tb_slot != 4'd0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (tb_slot != 4'd0) f_to = 1'b1;
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      f_bits[s] = tx;
      if (s == 0) f_rx = 8'h00;
      else if (s <= 8) f_rx[s-1] = tx;
      if (s == 0) f_g0 = grant;
      else if (grant != 4'b0000) f_glate = 1'b1;
      if (active) f_acthi = 1'b1;
      else        f_actlo = 1'b1;
      if (s == 1) f_gid = grant_id;
      if (slot !== 4'(s) || frame_end !== (s == 9)) f_misc = 1'b1;
      if (s == sa) begin req = ra; data = da; end
      if (s == sb) begin req = rb; data = db; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0000;
    data  = 32'h0;
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({slot, tx, grant, grant_id, active, frame_end} !== 14'b0)
      begin tests_failed++; $display("FAIL reset outputs: got slot=%0d tx=%b grant=%b id=%0d act=%b fe=%b expected all 0", slot, tx, grant, grant_id, active, frame_end); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (slot !== 4'd0 || tx !== 1'b0)
      begin tests_failed++; $display("FAIL reset hold: got slot=%0d tx=%b expected slot=0 tx=0", slot, tx); end
    reset = 1'b1;
  endtask

  task automatic test_idle();
    logic [1:0] ea;
    for (int f = 0; f < 2; f++) begin
      collect_frame(-1, 4'b0, 32'h0, -1, 4'b0, 32'h0);
      ea = 2'b01;
      tests_run++;
      if (f_to !== 1'b0) begin tests_failed++; $display("FAIL idle f%0d: slot 0 not reached, got timeout expected aligned", f); end
      tests_run++;
      if (f_bits !== 10'b10_0000_0000) begin tests_failed++; $display("FAIL idle f%0d tx slots9..0: got %b expected %b", f, f_bits, 10'b10_0000_0000); end
      tests_run++;
      if (f_rx !== 8'h00) begin tests_failed++; $display("FAIL idle f%0d rx byte: got %h expected 00", f, f_rx); end
      tests_run++;
      if (f_g0 !== 4'b0000 || f_glate !== 1'b0) begin tests_failed++; $display("FAIL idle f%0d grant: got %b/%b expected 0000/0", f, f_g0, f_glate); end
      tests_run++;
      if ({f_acthi, f_actlo} !== ea) begin tests_failed++; $display("FAIL idle f%0d active: got hi=%b lo=%b expected lo only", f, f_acthi, f_actlo); end
      tests_run++;
      if (f_misc !== 1'b0) begin tests_failed++; $display("FAIL idle f%0d slot/frame_end: got bad expected slots 0..9, frame_end at 9", f); end
    end
  endtask

  // Shared scenario runner body is written out in each task below.
  task automatic test_single_request();
    int         sa[3]     = '{4, 0, -1};
    logic [3:0] ra[3]     = '{4'b0100, 4'b0000, 4'b0000};
    logic       e_act[3]  = '{1'b0, 1'b1, 1'b0};
    logic [7:0] e_byte[3] = '{8'h00, 8'hA5, 8'h00};
    logic [3:0] e_g[3]    = '{4'b0000, 4'b0100, 4'b0000};
    logic [2:0] e_gid[3]  = '{3'd0, 3'd2, 3'd0};
    logic [1:0] ea;
    for (int f = 0; f < 3; f++) begin
      collect_frame(sa[f], ra[f], 32'h00A5_0000, -1, 4'b0, 32'h0);
      ea = e_act[f] ? 2'b10 : 2'b01;
      tests_run++;
      if (f_to !== 1'b0) begin tests_failed++; $display("FAIL single f%0d: slot 0 not reached, got timeout expected aligned", f); end
      tests_run++;
      if (f_bits !== {1'b1, e_byte[f], 1'b0}) begin tests_failed++; $display("FAIL single f%0d tx slots9..0: got %b expected %b", f, f_bits, {1'b1, e_byte[f], 1'b0}); end
      tests_run++;
      if (f_rx !== e_byte[f]) begin tests_failed++; $display("FAIL single f%0d rx byte: got %h expected %h", f, f_rx, e_byte[f]); end
      tests_run++;
      if (f_g0 !== e_g[f] || f_glate !== 1'b0) begin tests_failed++; $display("FAIL single f%0d grant: got %b/%b expected %b/0", f, f_g0, f_glate, e_g[f]); end
      tests_run++;
      if ({f_acthi, f_actlo} !== ea) begin tests_failed++; $display("FAIL single f%0d active: got hi=%b lo=%b expected %b", f, f_acthi, f_actlo, ea); end
      if (e_act[f]) begin
        tests_run++;
        if (f_gid !== e_gid[f]) begin tests_failed++; $display("FAIL single f%0d grant_id: got %0d expected %0d", f, f_gid, e_gid[f]); end
      end
      tests_run++;
      if (f_misc !== 1'b0) begin tests_failed++; $display("FAIL single f%0d slot/frame_end: got bad expected slots 0..9, frame_end at 9", f); end
    end
  endtask

  task automatic test_contention();
    int         sa[7]     = '{2, -1, -1, -1, -1, -1, 0};
    logic [3:0] ra[7]     = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
    logic       e_act[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] e_byte[7] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
    logic [3:0] e_g[7]    = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [2:0] e_gid[7]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    logic [1:0] ea;
    pulse_reset();
    for (int f = 0; f < 7; f++) begin
      collect_frame(sa[f], ra[f], 32'h4433_2211, -1, 4'b0, 32'h0);
      ea = e_act[f] ? 2'b10 : 2'b01;
      tests_run++;
      if (f_to !== 1'b0) begin tests_failed++; $display("FAIL contention f%0d: slot 0 not reached, got timeout expected aligned", f); end
      tests_run++;
      if (f_bits !== {1'b1, e_byte[f], 1'b0}) begin tests_failed++; $display("FAIL contention f%0d tx slots9..0: got %b expected %b", f, f_bits, {1'b1, e_byte[f], 1'b0}); end
      tests_run++;
      if (f_rx !== e_byte[f]) begin tests_failed++; $display("FAIL contention f%0d rx byte: got %h expected %h", f, f_rx, e_byte[f]); end
      tests_run++;
      if (f_g0 !== e_g[f] || f_glate !== 1'b0) begin tests_failed++; $display("FAIL contention f%0d grant: got %b/%b expected %b/0", f, f_g0, f_glate, e_g[f]); end
      tests_run++;
      if ({f_acthi, f_actlo} !== ea) begin tests_failed++; $display("FAIL contention f%0d active: got hi=%b lo=%b expected %b", f, f_acthi, f_actlo, ea); end
      if (e_act[f]) begin
        tests_run++;
        if (f_gid !== e_gid[f]) begin tests_failed++; $display("FAIL contention f%0d grant_id: got %0d expected %0d", f, f_gid, e_gid[f]); end
      end
      tests_run++;
      if (f_misc !== 1'b0) begin tests_failed++; $display("FAIL contention f%0d slot/frame_end: got bad expected slots 0..9, frame_end at 9", f); end
    end
  endtask

  // req[0] pulses and drops at slot 5; req[1] rises in slot 9; req[3] rises in slot 0.
  task automatic test_edge_timing();
    int         sa[5]     = '{1, 9, 0, 0, -1};
    logic [3:0] ra[5]     = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    int         sb[5]     = '{5, -1, -1, -1, -1};
    logic       e_act[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] e_byte[5] = '{8'h00, 8'h00, 8'h5A, 8'h3C, 8'h00};
    logic [3:0] e_g[5]    = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0000};
    logic [2:0] e_gid[5]  = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd0};
    logic [1:0] ea;
    for (int f = 0; f < 5; f++) begin
      collect_frame(sa[f], ra[f], 32'h3C00_5A77, sb[f], 4'b0000, 32'h3C00_5A77);
      ea = e_act[f] ? 2'b10 : 2'b01;
      tests_run++;
      if (f_to !== 1'b0) begin tests_failed++; $display("FAIL edge f%0d: slot 0 not reached, got timeout expected aligned", f); end
      tests_run++;
      if (f_bits !== {1'b1, e_byte[f], 1'b0}) begin tests_failed++; $display("FAIL edge f%0d tx slots9..0: got %b expected %b", f, f_bits, {1'b1, e_byte[f], 1'b0}); end
      tests_run++;
      if (f_rx !== e_byte[f]) begin tests_failed++; $display("FAIL edge f%0d rx byte: got %h expected %h", f, f_rx, e_byte[f]); end
      tests_run++;
      if (f_g0 !== e_g[f] || f_glate !== 1'b0) begin tests_failed++; $display("FAIL edge f%0d grant: got %b/%b expected %b/0", f, f_g0, f_glate, e_g[f]); end
      tests_run++;
      if ({f_acthi, f_actlo} !== ea) begin tests_failed++; $display("FAIL edge f%0d active: got hi=%b lo=%b expected %b", f, f_acthi, f_actlo, ea); end
      if (e_act[f]) begin
        tests_run++;
        if (f_gid !== e_gid[f]) begin tests_failed++; $display("FAIL edge f%0d grant_id: got %0d expected %0d", f, f_gid, e_gid[f]); end
      end
      tests_run++;
      if (f_misc !== 1'b0) begin tests_failed++; $display("FAIL edge f%0d slot/frame_end: got bad expected slots 0..9, frame_end at 9", f); end
    end
  endtask

  // data[7:0] changes to FF in slot 4 of the frame that carries 96.
  task automatic test_data_change();
    int          sa[3]     = '{9, 0, -1};
    logic [3:0]  ra[3]     = '{4'b0001, 4'b0000, 4'b0000};
    int          sb[3]     = '{-1, 4, -1};
    logic        e_act[3]  = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  e_byte[3] = '{8'h00, 8'h96, 8'h00};
    logic [3:0]  e_g[3]    = '{4'b0000, 4'b0001, 4'b0000};
    logic [1:0]  ea;
    for (int f = 0; f < 3; f++) begin
      collect_frame(sa[f], ra[f], 32'h0000_0096, sb[f], 4'b0000, 32'h0000_00FF);
      ea = e_act[f] ? 2'b10 : 2'b01;
      tests_run++;
      if (f_to !== 1'b0) begin tests_failed++; $display("FAIL datachg f%0d: slot 0 not reached, got timeout expected aligned", f); end
      tests_run++;
      if (f_bits !== {1'b1, e_byte[f], 1'b0}) begin tests_failed++; $display("FAIL datachg f%0d tx slots9..0: got %b expected %b", f, f_bits, {1'b1, e_byte[f], 1'b0}); end
      tests_run++;
      if (f_rx !== e_byte[f]) begin tests_failed++; $display("FAIL datachg f%0d rx byte: got %h expected %h", f, f_rx, e_byte[f]); end
      tests_run++;
      if (f_g0 !== e_g[f] || f_glate !== 1'b0) begin tests_failed++; $display("FAIL datachg f%0d grant: got %b/%b expected %b/0", f, f_g0, f_glate, e_g[f]); end
      tests_run++;
      if ({f_acthi, f_actlo} !== ea) begin tests_failed++; $display("FAIL datachg f%0d active: got hi=%b lo=%b expected %b", f, f_acthi, f_actlo, ea); end
      if (e_act[f]) begin
        tests_run++;
        if (f_gid !== 3'd0) begin tests_failed++; $display("FAIL datachg f%0d grant_id: got %0d expected 0", f, f_gid); end
      end
    end
  endtask

  // Requester 2 keeps req high after its grant and queues a second byte.
  task automatic test_back_to_back();
    int         sa[4]     = '{9, 3, 0, -1};
    logic [3:0] ra[4]     = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [31:0] da[4]    = '{32'h0081_0000, 32'h007E_0000, 32'h007E_0000, 32'h007E_0000};
    logic       e_act[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] e_byte[4] = '{8'h00, 8'h81, 8'h7E, 8'h00};
    logic [3:0] e_g[4]    = '{4'b0000, 4'b0100, 4'b0100, 4'b0000};
    logic [1:0] ea;
    for (int f = 0; f < 4; f++) begin
      collect_frame(sa[f], ra[f], da[f], -1, 4'b0, 32'h0);
      ea = e_act[f] ? 2'b10 : 2'b01;
      tests_run++;
      if (f_to !== 1'b0) begin tests_failed++; $display("FAIL b2b f%0d: slot 0 not reached, got timeout expected aligned", f); end
      tests_run++;
      if (f_bits !== {1'b1, e_byte[f], 1'b0}) begin tests_failed++; $display("FAIL b2b f%0d tx slots9..0: got %b expected %b", f, f_bits, {1'b1, e_byte[f], 1'b0}); end
      tests_run++;
      if (f_g0 !== e_g[f] || f_glate !== 1'b0) begin tests_failed++; $display("FAIL b2b f%0d grant: got %b/%b expected %b/0", f, f_g0, f_glate, e_g[f]); end
      tests_run++;
      if ({f_acthi, f_actlo} !== ea) begin tests_failed++; $display("FAIL b2b f%0d active: got hi=%b lo=%b expected %b", f, f_acthi, f_actlo, ea); end
      if (e_act[f]) begin
        tests_run++;
        if (f_gid !== 3'd2) begin tests_failed++; $display("FAIL b2b f%0d grant_id: got %0d expected 2", f, f_gid); end
      end
    end
  endtask

  // Reset hits slot 5 of requester 1's C3 frame; afterwards req[0] and req[1] both wait.
  task automatic test_reset_mid_frame();
    int         sa[3]     = '{-1, -1, 0};
    logic       e_act[3]  = '{1'b0, 1'b1, 1'b1};
    logic [7:0] e_byte[3] = '{8'h00, 8'h18, 8'hC3};
    logic [3:0] e_g[3]    = '{4'b0000, 4'b0001, 4'b0010};
    logic [2:0] e_gid[3]  = '{3'd0, 3'd0, 3'd1};
    logic [1:0] ea;
    collect_frame(9, 4'b0010, 32'h0000_C300, -1, 4'b0, 32'h0);
    @(negedge clk);
    tests_run++;
    if (slot !== 4'd0 || grant !== 4'b0010 || active !== 1'b1 || grant_id !== 3'd1)
      begin tests_failed++; $display("FAIL rstmid grant: got slot=%0d grant=%b act=%b id=%0d expected 0/0010/1/1", slot, grant, active, grant_id); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (slot !== 4'd2 || tx !== 1'b1)
      begin tests_failed++; $display("FAIL rstmid slot2: got slot=%0d tx=%b expected slot=2 tx=1", slot, tx); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (slot !== 4'd5 || active !== 1'b1)
      begin tests_failed++; $display("FAIL rstmid slot5: got slot=%0d act=%b expected slot=5 act=1", slot, active); end
    reset = 1'b0;
    req   = 4'b0011;
    data  = 32'h0000_C318;
    #1;
    tests_run++;
    if ({slot, tx, grant, grant_id, active, frame_end} !== 14'b0)
      begin tests_failed++; $display("FAIL rstmid async: got slot=%0d tx=%b grant=%b id=%0d act=%b fe=%b expected all 0", slot, tx, grant, grant_id, active, frame_end); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int f = 0; f < 3; f++) begin
      collect_frame(sa[f], 4'b0000, 32'h0000_C318, -1, 4'b0, 32'h0);
      ea = e_act[f] ? 2'b10 : 2'b01;
      tests_run++;
      if (f_to !== 1'b0) begin tests_failed++; $display("FAIL rstmid f%0d: slot 0 not reached, got timeout expected aligned", f); end
      tests_run++;
      if (f_bits !== {1'b1, e_byte[f], 1'b0}) begin tests_failed++; $display("FAIL rstmid f%0d tx slots9..0: got %b expected %b", f, f_bits, {1'b1, e_byte[f], 1'b0}); end
      tests_run++;
      if (f_g0 !== e_g[f] || f_glate !== 1'b0) begin tests_failed++; $display("FAIL rstmid f%0d grant: got %b/%b expected %b/0", f, f_g0, f_glate, e_g[f]); end
      tests_run++;
      if ({f_acthi, f_actlo} !== ea) begin tests_failed++; $display("FAIL rstmid f%0d active: got hi=%b lo=%b expected %b", f, f_acthi, f_actlo, ea); end
      if (e_act[f]) begin
        tests_run++;
        if (f_gid !== e_gid[f]) begin tests_failed++; $display("FAIL rstmid f%0d grant_id: got %0d expected %0d", f, f_gid, e_gid[f]); end
      end
      tests_run++;
      if (f_misc !== 1'b0) begin tests_failed++; $display("FAIL rstmid f%0d slot/frame_end: got bad expected slots 0..9, frame_end at 9", f); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_request();
    test_contention();
    test_edge_timing();
    test_data_change();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
